// File: rtl/alu4_pkg.sv
// Shared ALU op encoding and BIST sweep constants.
// Used by alu4, alu4_golden and alu4_bist.
package alu4_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } alu_op_t;

  localparam int NUM_VECTORS = 1024;
  localparam int VEC_W       = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } bist_state_t;

endpackage

// File: rtl/alu4_golden.sv
// Golden reference for the 4-bit ALU, vector {op,a,b} -> expected response.
// Define ALU4_BIST_SUB_OVF_EN to check SUB overflow as borrow (a<b).
import alu4_pkg::*;

module alu4_golden (
  input  alu_op_t    op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] exp_result_o,
  output logic       exp_overflow_o,
  output logic       ovf_check_o
);

  logic [4:0] sum;
  logic [3:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = a_i - b_i;

  // Expected result/overflow and whether overflow is compared
  always_comb begin
    exp_result_o   = '0;
    exp_overflow_o = 1'b0;
    ovf_check_o    = 1'b1;
    unique case (op_i)
      ADD: begin
        exp_result_o   = sum[3:0];
        exp_overflow_o = sum[4];
      end
      SUB: begin
        exp_result_o   = diff;
        exp_overflow_o = (a_i < b_i);
`ifdef ALU4_BIST_SUB_OVF_EN
        ovf_check_o    = 1'b1;
`else
        ovf_check_o    = 1'b0;
`endif
      end
      AND: exp_result_o = a_i & b_i;
      OR:  exp_result_o = a_i | b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu4_bist.sv
// Exhaustive self-test engine for alu4: sweeps all {op,a,b} vectors.
// SUB overflow checking follows ALU4_BIST_SUB_OVF_EN (see alu4_golden).
import alu4_pkg::*;

module alu4_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output alu_op_t          alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST =
    VEC_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  bist_state_t      state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;

  logic [3:0] exp_result;
  logic       exp_overflow;
  logic       ovf_check;
  logic       mismatch;

  alu4_golden u_golden (
    .op_i           (alu_op),
    .a_i            (alu_a),
    .b_i            (alu_b),
    .exp_result_o   (exp_result),
    .exp_overflow_o (exp_overflow),
    .ovf_check_o    (ovf_check)
  );

  assign mismatch = (alu_result != exp_result) ||
                    (ovf_check && (alu_overflow != exp_overflow));

  // State, vector index, settle counter and error log registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  // Sweep sequencing and response checking
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fev_q) begin
            fev_d  = 1'b1;
            fvec_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_op          = alu_op_t'(idx_q[9:8]);
  assign alu_a           = idx_q[7:4];
  assign alu_b           = idx_q[3:0];
  assign busy            = (state_q == S_WAIT) ||
                           (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_alu4_bist.sv
// Directed bench for alu4_bist with a behavioural alu4 and fault knobs.
// A second instance with ERR_W=4 covers error-count saturation.
`timescale 1ns/1ps
import alu4_pkg::*;

module tb_alu4_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   fault = 0;

  always #5 clk = ~clk;

  logic [3:0]  a0, b0, r0, a1, b1, r1;
  alu_op_t     op0, op1;
  logic        o0, o1;
  logic        busy0, done0, pass0, fev0;
  logic [10:0] err0;
  logic [9:0]  fvec0;
  logic        busy1, done1, pass1, fev1;
  logic [3:0]  err1;
  logic [9:0]  fvec1;

  // Correct alu4 behaviour plus injected faults
  function automatic logic [4:0] alu(
    input alu_op_t op, input logic [3:0] a,
    input logic [3:0] b, input int f);
    logic [4:0] s;
    logic [3:0] r;
    logic       o;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      ADD: begin r = s[3:0]; o = s[4]; end
      SUB: begin r = a - b; o = (a < b); end
      AND: begin r = a & b; o = 1'b0; end
      default: begin r = a | b; o = 1'b0; end
    endcase
    if (f == 1) r[0] = 1'b0;
    if (f == 2) o = 1'b1;
    return {o, r};
  endfunction

  assign {o0, r0} = alu(op0, a0, b0, fault);
  assign {o1, r1} = alu(op1, a1, b1, fault);

  alu4_bist #(.SETTLE_CYCLES(1), .ERR_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(a0), .alu_b(b0), .alu_op(op0),
    .alu_result(r0), .alu_overflow(o0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_valid(fev0),
    .first_err_vec(fvec0)
  );

  alu4_bist #(.SETTLE_CYCLES(1), .ERR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .alu_result(r1), .alu_overflow(o1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fev1),
    .first_err_vec(fvec1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " alu_a"}, int'(a0), 0);
    chk({tag, " alu_b"}, int'(b0), 0);
    chk({tag, " alu_op"}, int'(op0), 0);
    chk({tag, " busy"}, int'(busy0), 0);
    chk({tag, " done"}, int'(done0), 0);
    chk({tag, " pass"}, int'(pass0), 0);
    chk({tag, " err"}, int'(err0), 0);
    chk({tag, " fev"}, int'(fev0), 0);
    chk({tag, " fvec"}, int'(fvec0), 0);
    chk({tag, " sat busy"}, int'(busy1), 0);
  endtask

  // Pulse start for edge E and check the state right after it
  task automatic kick(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " E busy"}, int'(busy0), 1);
    chk({tag, " E done"}, int'(done0), 0);
    chk({tag, " E err clr"}, int'(err0), 0);
    chk({tag, " E fev clr"}, int'(fev0), 0);
    chk({tag, " E vec0"}, int'({op0, a0, b0}), 0);
  endtask

  // Count edges after E until done; pulses start at two chosen counts
  task automatic wait_done(input int p1, input int p2, output int n);
    n = 0;
    while (!done0 && n < 5000) begin
      start = (n == p1) || (n == p2);
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    if (!done0) begin
      bad++;
      total++;
      $display("FAIL timeout: done never rose after %0d cycles", n);
    end
  endtask

  typedef struct {
    string name;
    int    fault;
    int    err;
    int    fev;
    int    fvec;
    int    pass;
  } vec_t;

  vec_t tbl[3];
  int   n;
  int   ovf_err;

  initial begin
`ifdef ALU4_BIST_SUB_OVF_EN
    ovf_err = 784;
`else
    ovf_err = 648;
`endif
    tbl[0] = '{"clean", 0, 0,       0, 0, 1};
    tbl[1] = '{"res0",  1, 512,     1, 1, 0};
    tbl[2] = '{"ovf1",  2, ovf_err, 1, 0, 0};

    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle done", int'(done0), 0);
    chk("idle busy", int'(busy0), 0);

    foreach (tbl[i]) begin
      fault = tbl[i].fault;
      kick(tbl[i].name);
      wait_done(-1, -1, n);
      chk({tbl[i].name, " cycles"}, n, 2048);
      chk({tbl[i].name, " busy"}, int'(busy0), 0);
      chk({tbl[i].name, " err"}, int'(err0), tbl[i].err);
      chk({tbl[i].name, " fev"}, int'(fev0), tbl[i].fev);
      chk({tbl[i].name, " fvec"}, int'(fvec0), tbl[i].fvec);
      chk({tbl[i].name, " pass"}, int'(pass0), tbl[i].pass);
      chk({tbl[i].name, " last vec"},
          int'({op0, a0, b0}), 1023);
      chk({tbl[i].name, " sat err"}, int'(err1),
          (tbl[i].err > 15) ? 15 : tbl[i].err);
      chk({tbl[i].name, " sat fvec"}, int'(fvec1), tbl[i].fvec);
      chk({tbl[i].name, " sat fev"}, int'(fev1), tbl[i].fev);
    end

    // start pulses in WAIT (n=2) and CHECK (n=101) are ignored
    fault = 0;
    kick("ign");
    wait_done(2, 101, n);
    chk("ign cycles", n, 2048);
    chk("ign pass", int'(pass0), 1);

    // reset mid-sweep at vector 300
    fault = 1;
    kick("mid");
    n = 0;
    while (n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid vec300", int'({op0, a0, b0}), 300);
    chk("mid busy", int'(busy0), 1);
    chk("mid err", int'(err0), 150);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst busy", int'(busy0), 0);
    chk("post rst done", int'(done0), 0);

    fault = 0;
    kick("full");
    wait_done(-1, -1, n);
    chk("full cycles", n, 2048);
    chk("full pass", int'(pass0), 1);
    chk("full err", int'(err0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
